// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   N-channel push-button conditioner. Each channel has a 2-FF synchroniser,
//   a debouncer, one-cycle press/release pulses and an optional auto-repeat
//   generator. Channels are fully independent. All outputs are registered.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   btn_in     in   N_BTN  raw asynchronous button inputs, active-high
//   level      out  N_BTN  debounced button state
//   press      out  N_BTN  1-cycle pulse when level first shows 1
//   release_p  out  N_BTN  1-cycle pulse when level first shows 0
//   rpt        out  N_BTN  1-cycle auto-repeat pulse while held (enabled channels)
//   step       out  N_BTN  press | rpt
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int unsigned      N_BTN           = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      REPEAT_DELAY    = 25000000,
  parameter int unsigned      REPEAT_RATE     = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b011,
  parameter int unsigned      CNT_W           = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] rpt,
  output logic [N_BTN-1:0] step
);

  typedef enum logic [1:0] {
    REL = 2'd0,
    DLY = 2'd1,
    RPT = 2'd2
  } rp_state_e;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]       sync_q, sync_d;
    logic             sync_i;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;
    logic             step_q, step_d;
    rp_state_e        st_q, st_d;
    logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;

    // Two-stage synchroniser; nothing else looks at btn_in.
    assign sync_d = {sync_q[0], btn_in[i]};
    assign sync_i = sync_q[1];

    // Debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; accept the change on the last one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      if (sync_i != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = ~level_q;
          press_d = ~level_q;
          rel_d   = level_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Repeat FSM. It follows the *next* level so that it enters DLY on the
    // same edge that raises press, and a release landing on a due repeat
    // wins (no rpt that cycle).
    always_comb begin
      st_d     = st_q;
      rp_cnt_d = rp_cnt_q;
      rpt_d    = 1'b0;
      if (!REPEAT_MASK[i] || !level_d) begin
        st_d     = REL;
        rp_cnt_d = '0;
      end else begin
        unique case (st_q)
          REL: begin
            if (press_d) begin
              st_d     = DLY;
              rp_cnt_d = '0;
            end
          end
          DLY: begin
            if (rp_cnt_q == DLY_LAST) begin
              rpt_d    = 1'b1;
              rp_cnt_d = '0;
              st_d     = RPT;
            end else begin
              rp_cnt_d = rp_cnt_q + 1'b1;
            end
          end
          RPT: begin
            if (rp_cnt_q == RPT_LAST) begin
              rpt_d    = 1'b1;
              rp_cnt_d = '0;
            end else begin
              rp_cnt_d = rp_cnt_q + 1'b1;
            end
          end
          default: begin
            st_d     = REL;
            rp_cnt_d = '0;
          end
        endcase
      end
    end

    assign step_d = press_d | rpt_d;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q   <= '0;
        db_cnt_q <= '0;
        level_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        rpt_q    <= 1'b0;
        step_q   <= 1'b0;
        st_q     <= REL;
        rp_cnt_q <= '0;
      end else begin
        sync_q   <= sync_d;
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        rpt_q    <= rpt_d;
        step_q   <= step_d;
        st_q     <= st_d;
        rp_cnt_q <= rp_cnt_d;
      end
    end

    assign level[i]     = level_q;
    assign press[i]     = press_q;
    assign release_p[i] = rel_q;
    assign rpt[i]       = rpt_q;
    assign step[i]      = step_q;
  end

endmodule
